// File: rtl/sipm_tx_pkg.sv
// Shared definitions for the SiPM laser-link frame transmitter.
// Contents: parity mode codes, frame FSM state type, frame length helper.
package sipm_tx_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Number of chips in one frame: start + payload + optional parity + stops.
  function automatic int unsigned calc_nchip(input int unsigned data_bits,
                                             input int unsigned parity_mode,
                                             input int unsigned stop_bits);
    return 1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/sipm_sync_fifo.sv
// Small synchronous FIFO with registered full/empty/level flags.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, wr_data   write request and word (ignored while full)
//   pop             read request (ignored while empty)
//   rd_data_c       head-of-queue word, combinational from storage
//   full, empty     registered status flags
//   level           registered number of stored words
module sipm_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data_c,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push_c;
  logic             do_pop_c;
  logic [LVL_W-1:0] level_nxt;

  assign do_push_c = push && !full;
  assign do_pop_c  = pop && !empty;
  assign rd_data_c = mem[rd_ptr];

  // Next occupancy; simultaneous push and pop cancel out.
  always_comb begin
    level_nxt = level;
    case ({do_push_c, do_pop_c})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_nxt;
      full  <= (level_nxt == LVL_W'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

  // Storage needs no reset; occupancy is tracked by the flags above.
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/sipm_frame_tx.sv
// SiPM laser-link frame transmitter: buffers words and sends each as a
// start / payload / parity / stop chip frame, "1" chips as RZ pulses.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_data/s_valid/s_ready  word input handshake into the FIFO
//   tx_en               allows new frames to start
//   tx_out              registered laser drive (0 = dark)
//   busy                frame in progress
//   frame_done          one-cycle pulse after a frame's last stop chip
//   fifo_level          words queued
module sipm_frame_tx
  import sipm_tx_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 16,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PULSE_CLKS   = 8,
  parameter int unsigned PARITY_MODE  = 2,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned INVERT_DATA  = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_BITS-1:0]            s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic                            tx_en,
  output logic                            tx_out,
  output logic                            busy,
  output logic                            frame_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int unsigned NCHIP = calc_nchip(DATA_BITS, PARITY_MODE, STOP_BITS);
  localparam int unsigned PH_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned PHX_W = PH_W + 1;
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

  state_t               state, state_nxt;
  logic [PH_W-1:0]      phase, phase_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_word_c;
  logic [DATA_BITS-1:0] payload_c;
  logic                 par_calc_c;
  logic                 pop_c;
  logic                 load_c;
  logic                 shift_c;
  logic                 done_c;
  logic                 chip_end_c;
  logic                 chip_c;
  logic                 pulse_win_c;

  sipm_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s_valid),
    .wr_data   (s_data),
    .pop       (pop_c),
    .rd_data_c (fifo_word_c),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign s_ready = !fifo_full;

  // Payload chips as transmitted; parity covers these, not the raw word.
  assign payload_c  = (INVERT_DATA != 0) ? ~fifo_word_c : fifo_word_c;
  assign par_calc_c = (PARITY_MODE == PARITY_ODD) ? ~^payload_c : ^payload_c;

  assign chip_end_c  = (phase == PH_W'(CLKS_PER_BIT - 1));
  assign pulse_win_c = ({1'b0, phase} < PHX_W'(PULSE_CLKS));

  // Value of the chip currently being sent.
  always_comb begin
    chip_c = 1'b0;
    case (state)
      START:   chip_c = 1'b1;
      DATA:    chip_c = shreg[0];
      PARITY:  chip_c = par_bit;
      default: chip_c = 1'b0;
    endcase
  end

  // Frame sequencing; a finishing frame may chain straight into the next START.
  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    bit_cnt_nxt = bit_cnt;
    pop_c       = 1'b0;
    load_c      = 1'b0;
    shift_c     = 1'b0;
    done_c      = 1'b0;
    if (state != IDLE) phase_nxt = chip_end_c ? '0 : phase + PH_W'(1);
    case (state)
      IDLE: begin
        if (!fifo_empty && tx_en) begin
          state_nxt = START;
          pop_c     = 1'b1;
          load_c    = 1'b1;
        end
      end
      START: begin
        if (chip_end_c) begin
          state_nxt   = DATA;
          bit_cnt_nxt = '0;
        end
      end
      DATA: begin
        if (chip_end_c) begin
          shift_c = 1'b1;
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            bit_cnt_nxt = '0;
            state_nxt   = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (chip_end_c) begin
          state_nxt   = STOP;
          bit_cnt_nxt = '0;
        end
      end
      STOP: begin
        if (chip_end_c) begin
          if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            done_c      = 1'b1;
            bit_cnt_nxt = '0;
            if (!fifo_empty && tx_en) begin
              state_nxt = START;
              pop_c     = 1'b1;
              load_c    = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tx_out lags the chip/phase state by one cycle; a frame spans NCHIP chips.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tx_out     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      phase   <= phase_nxt;
      bit_cnt <= bit_cnt_nxt;
      if (load_c) begin
        shreg   <= payload_c;
        par_bit <= par_calc_c;
      end else if (shift_c) begin
        shreg <= shreg >> 1;
      end
      tx_out     <= chip_c && pulse_win_c;
      busy       <= (state_nxt != IDLE);
      frame_done <= done_c;
    end
  end

endmodule

// File: tb/tb_sipm_frame_tx.sv
// Scoreboard bench for sipm_frame_tx: three instances (odd, even, no parity)
// share stimulus; monitors capture each frame's tx_out/frame_done waveform.
module tb_sipm_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       tx_en;

  logic       s_ready_a    [3];
  logic       tx_out_a     [3];
  logic       busy_a       [3];
  logic       frame_done_a [3];
  logic [2:0] lvl_a        [3];

  int total = 0;
  int bad   = 0;
  int epoch = 0;
  int fd_cnt   [3];
  int run_len  [3];
  int last_run [3];

  logic [63:0] q0 [$];
  logic [63:0] q1 [$];
  logic [63:0] q2 [$];

  always #5 clk = ~clk;

  sipm_frame_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PULSE_CLKS(2), .PARITY_MODE(2),
                  .STOP_BITS(1), .INVERT_DATA(1), .FIFO_DEPTH(4)) u_odd (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_a[0]),
    .tx_en(tx_en), .tx_out(tx_out_a[0]), .busy(busy_a[0]),
    .frame_done(frame_done_a[0]), .fifo_level(lvl_a[0]));

  sipm_frame_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PULSE_CLKS(2), .PARITY_MODE(1),
                  .STOP_BITS(1), .INVERT_DATA(1), .FIFO_DEPTH(4)) u_even (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_a[1]),
    .tx_en(tx_en), .tx_out(tx_out_a[1]), .busy(busy_a[1]),
    .frame_done(frame_done_a[1]), .fifo_level(lvl_a[1]));

  sipm_frame_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PULSE_CLKS(2), .PARITY_MODE(0),
                  .STOP_BITS(1), .INVERT_DATA(1), .FIFO_DEPTH(4)) u_none (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_a[2]),
    .tx_en(tx_en), .tx_out(tx_out_a[2]), .busy(busy_a[2]),
    .frame_done(frame_done_a[2]), .fifo_level(lvl_a[2]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected tx_out samples: chip c occupies samples 4c..4c+3, "1" = 1100.
  function automatic logic [63:0] exp_wave(input logic [7:0] d, input int mode);
    logic [15:0] chips;
    logic [7:0]  pl;
    int          n;
    pl = ~d;
    chips = '0;
    chips[0] = 1'b1;
    for (int i = 0; i < 8; i++) chips[1+i] = pl[i];
    n = 9;
    if (mode == 1) begin chips[9] = ^pl;  n = 10; end
    if (mode == 2) begin chips[9] = ~^pl; n = 10; end
    chips[n] = 1'b0;
    n = n + 1;
    exp_wave = '0;
    for (int c = 0; c < n; c++)
      for (int p = 0; p < 4; p++)
        exp_wave[c*4+p] = chips[c] && (p < 2);
  endfunction

  // Frame statistics per instance, sampled on the falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (frame_done_a[k] === 1'b1) fd_cnt[k] <= fd_cnt[k] + 1;
      if (busy_a[k] === 1'b1) run_len[k] <= run_len[k] + 1;
      else begin
        if (run_len[k] != 0) last_run[k] <= run_len[k];
        run_len[k] <= 0;
      end
    end
  end

  // Every frame begins with the start chip pulse; capture len samples from there.
  task automatic monitor(input int k, input int len);
    logic [63:0] w, fd, ew;
    int          ep;
    bit          aborted;
    bit          have;
    forever begin
      @(negedge clk);
      if (tx_out_a[k] === 1'b1) begin
        ep = epoch;
        w = '0;
        fd = '0;
        aborted = 1'b0;
        for (int i = 0; i < len; i++) begin
          if (i > 0) @(negedge clk);
          if (epoch != ep) begin
            aborted = 1'b1;
            break;
          end
          w[i]  = tx_out_a[k];
          fd[i] = frame_done_a[k];
        end
        if (!aborted) begin
          have = 1'b0;
          ew = '0;
          case (k)
            0: if (q0.size() > 0) begin ew = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin ew = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin ew = q2.pop_front(); have = 1'b1; end
          endcase
          chk($sformatf("frame_expected[%0d]", k), have, 1'b1);
          if (have) begin
            chk($sformatf("wave[%0d]", k), w, ew);
            chk($sformatf("done_pos[%0d]", k), fd, 64'(1) << (len - 1));
          end
        end
      end
    end
  endtask

  initial monitor(0, 44);
  initial monitor(1, 44);
  initial monitor(2, 40);

  // Called at a falling edge; the word transfers on the following rising edge.
  task automatic push_word(input logic [7:0] d);
    s_data  = d;
    s_valid = 1'b1;
    q0.push_back(exp_wave(d, 2));
    q1.push_back(exp_wave(d, 1));
    q2.push_back(exp_wave(d, 0));
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    repeat (3) @(negedge clk);
    while ((busy_a[0] || busy_a[1] || busy_a[2]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", n < budget, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          fd0;
    bit          any_tx;
    logic [2:0]  prev;
    logic [15:0] seq;
    int          nchg;
    int          n;

    rst = 1'b1; s_valid = 1'b0; s_data = '0; tx_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_tx_out", tx_out_a[0], 1'b0);
    chk("rst_busy", busy_a[0], 1'b0);
    chk("rst_frame_done", frame_done_a[0], 1'b0);
    chk("rst_level", lvl_a[0], 3'd0);
    chk("rst_s_ready", s_ready_a[0], 1'b1);

    // Single frame 0xA5, with start latency.
    tx_en = 1'b1;
    fd0 = fd_cnt[0];
    push_word(8'hA5);
    @(negedge clk);
    chk("lat_t1_tx_out", tx_out_a[0], 1'b0);
    chk("lat_t1_busy", busy_a[0], 1'b1);
    @(negedge clk);
    chk("lat_t2_tx_out", tx_out_a[0], 1'b1);
    wait_idle(200);
    chk("a5_busy_odd", last_run[0], 44);
    chk("a5_busy_even", last_run[1], 44);
    chk("a5_busy_none", last_run[2], 40);
    chk("a5_done_cnt", fd_cnt[0] - fd0, 1);

    // Single frame 0x00.
    fd0 = fd_cnt[1];
    push_word(8'h00);
    wait_idle(200);
    chk("z_busy_even", last_run[1], 44);
    chk("z_done_cnt", fd_cnt[1] - fd0, 1);

    // Fill the FIFO with tx_en low, then release for back-to-back frames.
    tx_en = 1'b0;
    fd0 = fd_cnt[0];
    push_word(8'h12);
    push_word(8'h34);
    push_word(8'hFF);
    chk("b2b_ready_3", s_ready_a[0], 1'b1);
    push_word(8'h81);
    chk("b2b_ready_4", s_ready_a[0], 1'b0);
    chk("b2b_level_4", lvl_a[0], 3'd4);
    prev = lvl_a[0];
    seq = '0;
    nchg = 0;
    tx_en = 1'b1;
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      if (lvl_a[0] != prev) begin
        seq = {seq[11:0], 1'b0, lvl_a[0]};
        prev = lvl_a[0];
        nchg++;
      end
      if (n > 5 && !busy_a[0] && !busy_a[1] && !busy_a[2]) break;
    end
    chk("b2b_finished", n < 400, 1'b1);
    repeat (2) @(negedge clk);
    chk("b2b_level_seq", seq, 16'h3210);
    chk("b2b_level_chg", nchg, 4);
    chk("b2b_busy_odd", last_run[0], 176);
    chk("b2b_busy_none", last_run[2], 160);
    chk("b2b_done_cnt", fd_cnt[0] - fd0, 4);

    // tx_en gating.
    tx_en = 1'b0;
    fd0 = fd_cnt[0];
    push_word(8'h5A);
    push_word(8'hC3);
    any_tx = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (tx_out_a[0] || busy_a[0]) any_tx = 1'b1;
    end
    chk("gate_dark", any_tx, 1'b0);
    chk("gate_level", lvl_a[0], 3'd2);
    tx_en = 1'b1;
    @(negedge clk);
    chk("gate_start_busy", busy_a[0], 1'b1);
    chk("gate_start_level", lvl_a[0], 3'd1);
    repeat (10) @(negedge clk);
    tx_en = 1'b0;
    wait_idle(200);
    chk("gate_one_done", fd_cnt[0] - fd0, 1);
    repeat (20) @(negedge clk);
    chk("gate_hold_busy", busy_a[0], 1'b0);
    chk("gate_hold_level", lvl_a[0], 3'd1);
    tx_en = 1'b1;
    wait_idle(200);
    chk("gate_two_done", fd_cnt[0] - fd0, 2);
    chk("gate_level_end", lvl_a[0], 3'd0);

    // Reset at cycle 20 of a frame, with a second word queued.
    push_word(8'h0F);
    push_word(8'hF0);
    n = 0;
    while (!busy_a[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rstf_started", busy_a[0], 1'b1);
    repeat (19) @(negedge clk);
    fd0 = fd_cnt[0];
    rst = 1'b1;
    epoch++;
    q0.delete();
    q1.delete();
    q2.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("rstf_tx_out", tx_out_a[0], 1'b0);
    chk("rstf_busy", busy_a[0], 1'b0);
    chk("rstf_level", lvl_a[0], 3'd0);
    chk("rstf_frame_done", frame_done_a[0], 1'b0);
    repeat (5) @(negedge clk);
    chk("rstf_no_done", fd_cnt[0] - fd0, 0);
    chk("rstf_still_idle", busy_a[0], 1'b0);
    push_word(8'h3C);
    wait_idle(200);
    chk("rstf_new_busy", last_run[0], 44);
    chk("rstf_new_done", fd_cnt[0] - fd0, 1);

    repeat (5) @(negedge clk);
    chk("q_empty_odd", q0.size(), 0);
    chk("q_empty_even", q1.size(), 0);
    chk("q_empty_none", q2.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
